// File: rtl/bpsk_modulator.sv
// bpsk_modulator: LSB-first BPSK sine modulator (clk, arst, en, in word -> registered offset-binary signal_out)
module bpsk_modulator #(
  parameter int SINE_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  en,
  input  logic [DATA_WIDTH:0]   in,
  output logic [SINE_WIDTH-1:0] signal_out
);
  localparam int N = 2 ** DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH + 1);
  localparam logic [SINE_WIDTH-1:0] MID = {1'b1, {(SINE_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] HALF = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  function automatic logic [SINE_WIDTH-1:0] lut_val(input int k);
    real a, s;
    int r;
    a = 2.0 ** (SINE_WIDTH - 1) - 1.0;
    s = a * $sin(2.0 * 3.14159265358979323846 * k / N);
    r = s >= 0.0 ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
    return SINE_WIDTH'(2 ** (SINE_WIDTH - 1) + r);
  endfunction
  logic [SINE_WIDTH-1:0] lut [N];
  for (genvar k = 0; k < N; k++) begin : g_lut
    assign lut[k] = lut_val(k);
  end
  logic [DATA_WIDTH-1:0] sine_cnt, idx;
  logic [SW-1:0]         sel_cnt;
  logic [DATA_WIDTH:0]   sel, w;
  logic                  b;
  always_comb begin
    w   = (sine_cnt == '0 && sel_cnt == '0) ? in : sel;
    b   = w[sel_cnt];
    idx = b ? sine_cnt : sine_cnt + HALF;
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      sine_cnt   <= '0;
      sel_cnt    <= '0;
      sel        <= '0;
      signal_out <= MID;
    end else if (en) begin
      signal_out <= lut[idx];
      sel        <= w;
      sine_cnt   <= sine_cnt + 1'b1;
      if (&sine_cnt) sel_cnt <= (sel_cnt == SW'(DATA_WIDTH)) ? '0 : sel_cnt + 1'b1;
    end
endmodule

// File: tb/tb_bpsk_modulator.sv
// tb_bpsk_modulator: self-checking bench for bpsk_modulator against a word/position model
module tb_bpsk_modulator;
  localparam int N = 256;
  localparam int WORD = 9 * N;
  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        en = 1'b0;
  logic [8:0]  in = '0;
  logic [11:0] signal_out;
  int ref_lut [N];
  int pass_cnt = 0;
  int total_cnt = 0;
  int pos = 0;
  int exp_out = 2048;
  logic [8:0] word = '0;
  bit chk_on = 1'b0;
  bpsk_modulator dut (
    .clk(clk),
    .arst(arst),
    .en(en),
    .in(in),
    .signal_out(signal_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, want %0d", name, act, req);
  endtask
  function automatic int model(input logic [8:0] wd, input int p);
    int ph;
    ph = p % N;
    return wd[p / N] ? ref_lut[ph] : ref_lut[(ph + N / 2) % N];
  endfunction
  always @(posedge clk or posedge arst)
    if (arst) begin
      pos = 0;
      exp_out = 2048;
    end else if (en) begin
      if (pos == 0) word = in;
      exp_out = model(word, pos);
      pos = (pos + 1) % WORD;
    end
  always @(negedge clk)
    if (chk_on) check("stream", int'(signal_out), exp_out);
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    for (int k = 0; k < N; k++) begin
      real s;
      s = 2047.0 * $sin(2.0 * 3.14159265358979323846 * k / N);
      ref_lut[k] = 2048 + (s >= 0.0 ? $rtoi(s + 0.5) : -$rtoi(0.5 - s));
    end
    check("lut0", ref_lut[0], 2048);
    check("lut1", ref_lut[1], 2098);
    check("lut64", ref_lut[64], 4095);
    check("lut192", ref_lut[192], 1);
    step(3);
    chk_on = 1'b1;
    check("reset_out", int'(signal_out), 2048);
    arst = 1'b0;
    step(5);
    check("idle_out", int'(signal_out), 2048);
    check("idle_sine_cnt", int'(dut.sine_cnt), 0);
    check("idle_sel_cnt", int'(dut.sel_cnt), 0);
    in = 9'h1FF;
    en = 1'b1;
    step(1);   check("ones_e1", int'(signal_out), 2048);
    step(1);   check("ones_e2", int'(signal_out), 2098);
    step(63);  check("ones_e65", int'(signal_out), 4095);
    step(64);  check("ones_e129", int'(signal_out), 2048);
    step(64);  check("ones_e193", int'(signal_out), 1);
    step(63);  check("ones_sel_cnt", int'(dut.sel_cnt), 1);
    step(WORD - 256);
    in = 9'h000;
    step(1);   check("zeros_e1", int'(signal_out), 2048);
    step(64);  check("zeros_e65", int'(signal_out), 1);
    step(128); check("zeros_e193", int'(signal_out), 4095);
    step(WORD - 193);
    in = 9'b0_0000_0010;
    step(1);   check("b1_e1", int'(signal_out), 2048);
    step(64);  check("b1_e65", int'(signal_out), 1);
    step(256); check("b1_e321", int'(signal_out), 4095);
    step(679);
    in = 9'h1FF;
    en = 1'b0;
    step(500); check("pause_hold", int'(signal_out), model(9'b0_0000_0010, 999));
    check("pause_sine_cnt", int'(dut.sine_cnt), 1000 % N);
    en = 1'b1;
    step(WORD - 1000);
    step(1);   check("new_word_e1", int'(signal_out), 2048);
    step(1);   check("new_word_e2", int'(signal_out), 2098);
    step(698);
    in = 9'h000;
    arst = 1'b1;
    #1;
    check("arst_out", int'(signal_out), 2048);
    check("arst_sine_cnt", int'(dut.sine_cnt), 0);
    check("arst_sel_cnt", int'(dut.sel_cnt), 0);
    step(2);
    arst = 1'b0;
    step(1);   check("fresh_e1", int'(signal_out), 2048);
    step(64);  check("fresh_e65", int'(signal_out), 1);
    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
